board_state_manager: RTL and testbench

- Owns the authoritative 8x8 chess board and the side-to-move.
- Accepts move requests from the input/cursor stage and performs cheap legality pre-checks: occupancy, colour and null move.
- Forwards surviving requests to board_validator, waits for its verdict, then commits or rejects the move.
- Sits directly upstream of board_validator (drives its inputs) and downstream of the user-input FSM; also feeds the display.

---
 rtl/chess_pkg.sv | 55 +++++
 rtl/board_state_manager_precheck.sv | 26 ++
 rtl/board_state_manager.sv | 168 ++++++++++++++++
 tb/tb_board_state_manager.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess encodings: piece codes, reject reasons, start position and colour helpers.
package chess_pkg;

   typedef enum logic [3:0] {
      W_ROOK   = 4'd0,
      W_KNIGHT = 4'd1,
      W_BISHOP = 4'd2,
      W_QUEEN  = 4'd3,
      W_KING   = 4'd4,
      W_PAWN   = 4'd5,
      B_ROOK   = 4'd6,
      B_KNIGHT = 4'd7,
      B_BISHOP = 4'd8,
      B_QUEEN  = 4'd9,
      B_KING   = 4'd10,
      B_PAWN   = 4'd11,
      EMPTY    = 4'hF
   } piece_t;

   typedef enum logic [2:0] {
      RC_NONE        = 3'd0,
      RC_EMPTY_SRC   = 3'd1,
      RC_WRONG_COLOR = 3'd2,
      RC_SELF_TARGET = 3'd3,
      RC_ILLEGAL     = 3'd4,
      RC_TIMEOUT     = 3'd5
   } reject_code_t;

   typedef logic [7:0][7:0][3:0] board_t;

   // Back ranks packed with x=7 first so that ROW[x] selects file x.
   localparam logic [7:0][3:0] ROW_WHITE_BACK = {4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
   localparam logic [7:0][3:0] ROW_BLACK_BACK = {4'd6, 4'd7, 4'd8, 4'd10, 4'd9, 4'd8, 4'd7, 4'd6};

   function automatic logic is_white(input logic [3:0] p);
      return (p < 4'd6);
   endfunction

   function automatic logic is_black(input logic [3:0] p);
      return (p >= 4'd6) && (p <= 4'd11);
   endfunction

   function automatic board_t start_board();
      board_t b;
      for (int x = 0; x < 8; x++) begin
         for (int y = 0; y < 8; y++) b[x][y] = EMPTY;
         b[x][0] = ROW_WHITE_BACK[x];
         b[x][1] = W_PAWN;
         b[x][6] = B_PAWN;
         b[x][7] = ROW_BLACK_BACK[x];
      end
      return b;
   endfunction

endpackage

// File: rtl/board_state_manager_precheck.sv
// Cheap combinational legality screen: occupancy, side to move, null/self-capture.
module move_precheck
   import chess_pkg::*;
(
   input  logic [3:0]   src,
   input  logic [3:0]   dst,
   input  logic [2:0]   old_x,
   input  logic [2:0]   old_y,
   input  logic [2:0]   new_x,
   input  logic [2:0]   new_y,
   input  logic         white_turn,
   output reject_code_t code
);

   always_comb begin
      code = RC_NONE;
      if (src == EMPTY)
         code = RC_EMPTY_SRC;
      else if (is_white(src) != white_turn)
         code = RC_WRONG_COLOR;
      else if ((old_x == new_x && old_y == new_y) ||
               (dst != EMPTY && is_white(dst) == is_white(src)))
         code = RC_SELF_TARGET;
   end

endmodule

// File: rtl/board_state_manager.sv
// Authoritative board + side to move; screens requests, defers to board_validator, commits or rejects.
// state     | meaning
// IDLE      | ready for a request
// PRECHECK  | occupancy / colour / null-move screen
// LAUNCH    | one-cycle strobe to the validator
// WAIT_VAL  | waiting for verdict, timeout counting
// COMMIT    | apply move, toggle turn
// REJECT    | report reject_code
// GAME_OVER | king captured, absorbing until reset
module board_state_manager
   import chess_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int MOVE_CNT_W     = 10
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  move_req,
   input  logic [2:0]            req_old_x,
   input  logic [2:0]            req_old_y,
   input  logic [2:0]            req_new_x,
   input  logic [2:0]            req_new_y,
   output logic                  move_ready,
   output logic [2:0]            val_old_x,
   output logic [2:0]            val_old_y,
   output logic [2:0]            val_new_x,
   output logic [2:0]            val_new_y,
   output logic [3:0]            val_piece_type,
   output logic                  val_valid_input,
   input  logic                  val_valid_output,
   input  logic                  val_valid_move,
   output logic [7:0][7:0][3:0]  board_out,
   output logic                  white_turn,
   output logic                  move_done,
   output logic                  move_rejected,
   output logic [2:0]            reject_code,
   output logic [3:0]            captured_piece,
   output logic [MOVE_CNT_W-1:0] move_count,
   output logic                  game_over
);

   typedef enum logic [2:0] {
      S_IDLE, S_PRECHECK, S_LAUNCH, S_WAIT_VAL, S_COMMIT, S_REJECT, S_GAME_OVER
   } state_t;

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   state_t       state;
   logic [TMO_W-1:0] tmo_cnt;
   reject_code_t pend_code;
   reject_code_t pre_code;
   logic [3:0]   src;
   logic [3:0]   dst;
   logic [3:0]   moved;

   assign src        = board_out[val_old_x][val_old_y];
   assign dst        = board_out[val_new_x][val_new_y];
   assign move_ready = (state == S_IDLE);

   move_precheck u_precheck (
      .src        (src),
      .dst        (dst),
      .old_x      (val_old_x),
      .old_y      (val_old_y),
      .new_x      (val_new_x),
      .new_y      (val_new_y),
      .white_turn (white_turn),
      .code       (pre_code)
   );

   // Pawns reaching the far rank always become queens.
   always_comb begin
      moved = src;
      if (src == W_PAWN && val_new_y == 3'd7)
         moved = W_QUEEN;
      else if (src == B_PAWN && val_new_y == 3'd0)
         moved = B_QUEEN;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         board_out       <= start_board();
         white_turn      <= 1'b1;
         move_count      <= '0;
         game_over       <= 1'b0;
         move_done       <= 1'b0;
         move_rejected   <= 1'b0;
         reject_code     <= RC_NONE;
         captured_piece  <= EMPTY;
         val_old_x       <= '0;
         val_old_y       <= '0;
         val_new_x       <= '0;
         val_new_y       <= '0;
         val_piece_type  <= '0;
         val_valid_input <= 1'b0;
         tmo_cnt         <= '0;
         pend_code       <= RC_NONE;
      end else begin
         move_done       <= 1'b0;
         move_rejected   <= 1'b0;
         val_valid_input <= 1'b0;
         case (state)
            S_IDLE: begin
               if (move_req) begin
                  val_old_x <= req_old_x;
                  val_old_y <= req_old_y;
                  val_new_x <= req_new_x;
                  val_new_y <= req_new_y;
                  state     <= S_PRECHECK;
               end
            end
            S_PRECHECK: begin
               if (pre_code != RC_NONE) begin
                  pend_code <= pre_code;
                  state     <= S_REJECT;
               end else begin
                  val_piece_type <= src;
                  state          <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               val_valid_input <= 1'b1;
               tmo_cnt         <= '0;
               state           <= S_WAIT_VAL;
            end
            S_WAIT_VAL: begin
               // A verdict arriving on the timeout cycle still counts.
               if (val_valid_output) begin
                  if (val_valid_move) begin
                     state <= S_COMMIT;
                  end else begin
                     pend_code <= RC_ILLEGAL;
                     state     <= S_REJECT;
                  end
               end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                  pend_code <= RC_TIMEOUT;
                  state     <= S_REJECT;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_COMMIT: begin
               board_out[val_new_x][val_new_y] <= moved;
               board_out[val_old_x][val_old_y] <= EMPTY;
               captured_piece <= dst;
               white_turn     <= ~white_turn;
               move_count     <= move_count + 1'b1;
               move_done      <= 1'b1;
               if (dst == W_KING || dst == B_KING) begin
                  game_over <= 1'b1;
                  state     <= S_GAME_OVER;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_REJECT: begin
               move_rejected <= 1'b1;
               reject_code   <= pend_code;
               state         <= S_IDLE;
            end
            S_GAME_OVER: state <= S_GAME_OVER;
            default:     state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_board_state_manager.sv
// Directed scoreboard bench for board_state_manager with the bench acting as the validator.
module tb_board_state_manager;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 move_req;
   logic [2:0]           req_old_x, req_old_y, req_new_x, req_new_y;
   logic                 move_ready;
   logic [2:0]           val_old_x, val_old_y, val_new_x, val_new_y;
   logic [3:0]           val_piece_type;
   logic                 val_valid_input;
   logic                 val_valid_output;
   logic                 val_valid_move;
   logic [7:0][7:0][3:0] board_out;
   logic                 white_turn;
   logic                 move_done;
   logic                 move_rejected;
   logic [2:0]           reject_code;
   logic [3:0]           captured_piece;
   logic [9:0]           move_count;
   logic                 game_over;

   always #5 clk = ~clk;

   board_state_manager #(.TIMEOUT_CYCLES(64), .MOVE_CNT_W(10)) dut (
      .clk              (clk),
      .reset            (reset),
      .move_req         (move_req),
      .req_old_x        (req_old_x),
      .req_old_y        (req_old_y),
      .req_new_x        (req_new_x),
      .req_new_y        (req_new_y),
      .move_ready       (move_ready),
      .val_old_x        (val_old_x),
      .val_old_y        (val_old_y),
      .val_new_x        (val_new_x),
      .val_new_y        (val_new_y),
      .val_piece_type   (val_piece_type),
      .val_valid_input  (val_valid_input),
      .val_valid_output (val_valid_output),
      .val_valid_move   (val_valid_move),
      .board_out        (board_out),
      .white_turn       (white_turn),
      .move_done        (move_done),
      .move_rejected    (move_rejected),
      .reject_code      (reject_code),
      .captured_piece   (captured_piece),
      .move_count       (move_count),
      .game_over        (game_over)
   );

   typedef struct {
      bit         done;
      logic [2:0] code;
      int         lat;
      logic [3:0] ptype;
   } exp_t;

   exp_t sb[$];
   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0][7:0][3:0] bm;
   logic       turn_m, over_m;
   logic [9:0] cnt_m;
   logic [2:0] rc_m;
   logic [3:0] cap_m;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0][7:0][3:0] start_pos();
      logic [7:0][7:0][3:0] b;
      int back[8];
      back = '{0, 1, 2, 3, 4, 2, 1, 0};
      for (int x = 0; x < 8; x++) begin
         for (int y = 0; y < 8; y++) b[x][y] = 4'hF;
         b[x][0] = 4'(back[x]);
         b[x][1] = 4'd5;
         b[x][6] = 4'd11;
         b[x][7] = 4'(back[x] + 6);
      end
      return b;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      bm = start_pos(); turn_m = 1'b1; over_m = 1'b0;
      cnt_m = '0; rc_m = 3'd0; cap_m = 4'hF;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_board"}, board_out, bm);
      chk({tag, "_turn"}, white_turn, turn_m);
      chk({tag, "_count"}, move_count, cnt_m);
      chk({tag, "_game_over"}, game_over, over_m);
      chk({tag, "_reject_code"}, reject_code, rc_m);
      chk({tag, "_captured"}, captured_piece, cap_m);
   endtask

   // mode 0: validator approves, 1: validator refuses, 2: validator silent
   task automatic run_move(input int ox, input int oy, input int nx, input int ny,
                           input int mode, input int dly);
      exp_t e;
      logic [3:0] s, d, p;
      int t, launch_t, n_launch;
      bit seen;
      logic [3:0] l_ptype;
      logic [11:0] l_coord;
      s = bm[ox][oy];
      d = bm[nx][ny];
      e.done = 1'b0;
      e.ptype = s;
      if (s == 4'hF)                                e.code = 3'd1;
      else if ((s < 4'd6) != turn_m)                e.code = 3'd2;
      else if ((ox == nx && oy == ny) ||
               (d != 4'hF && ((d < 4'd6) == (s < 4'd6)))) e.code = 3'd3;
      else if (mode == 0)                            e.code = 3'd0;
      else if (mode == 1)                            e.code = 3'd4;
      else                                           e.code = 3'd5;
      if (e.code inside {3'd1, 3'd2, 3'd3}) e.lat = 2;
      else if (e.code == 3'd5)              e.lat = 67;
      else                                  e.lat = 4 + dly;
      if (e.code == 3'd0) begin
         e.done = 1'b1;
         p = s;
         if (s == 4'd5 && ny == 7)  p = 4'd3;
         if (s == 4'd11 && ny == 0) p = 4'd9;
         bm[nx][ny] = p;
         bm[ox][oy] = 4'hF;
         cap_m  = d;
         turn_m = ~turn_m;
         cnt_m  = cnt_m + 10'd1;
         if (d == 4'd4 || d == 4'd10) over_m = 1'b1;
      end else begin
         rc_m = e.code;
      end

      t = 0;
      while (move_ready !== 1'b1 && t < 20) begin
         @(posedge clk); #1; t++;
      end
      chk("ready_before_req", move_ready, 1'b1);
      req_old_x = 3'(ox); req_old_y = 3'(oy);
      req_new_x = 3'(nx); req_new_y = 3'(ny);
      move_req  = 1'b1;
      sb.push_back(e);
      @(posedge clk); #1;
      move_req = 1'b0;

      t = 0; n_launch = 0; launch_t = 0; seen = 1'b0;
      l_ptype = '0; l_coord = '0;
      while (!seen && t < 200) begin
         @(posedge clk); #1; t++;
         if (val_valid_input === 1'b1) begin
            n_launch++;
            launch_t = t;
            l_ptype  = val_piece_type;
            l_coord  = {val_old_x, val_old_y, val_new_x, val_new_y};
         end
         if (move_done === 1'b1 || move_rejected === 1'b1) seen = 1'b1;
         if (n_launch > 0 && mode != 2 && t == launch_t + dly) begin
            val_valid_output = 1'b1;
            val_valid_move   = (mode == 0);
         end else begin
            val_valid_output = 1'b0;
            val_valid_move   = 1'b0;
         end
      end
      val_valid_output = 1'b0;
      val_valid_move   = 1'b0;

      chk("outcome_within_bound", seen, 1'b1);
      e = sb.pop_front();
      chk("move_done", move_done, e.done);
      chk("move_rejected", move_rejected, !e.done);
      chk("latency", t, e.lat);
      chk("launch_count", n_launch, (e.code inside {3'd0, 3'd4, 3'd5}) ? 1 : 0);
      if (n_launch > 0) begin
         chk("val_piece_type", l_ptype, e.ptype);
         chk("val_coords", l_coord, {3'(ox), 3'(oy), 3'(nx), 3'(ny)});
      end
      check_state("outcome");
      chk("ready_after", move_ready, !over_m);
      @(posedge clk); #1;
      chk("pulses_clear", {move_done, move_rejected}, 2'b00);
   endtask

   initial begin
      int ev;
      reset = 1'b0; move_req = 1'b0;
      req_old_x = '0; req_old_y = '0; req_new_x = '0; req_new_y = '0;
      val_valid_output = 1'b0; val_valid_move = 1'b0;
      @(posedge clk); #1;
      do_reset();

      check_state("reset");
      chk("reset_ready", move_ready, 1'b1);
      chk("reset_pulses", {move_done, move_rejected, val_valid_input}, 3'b000);
      chk("reset_val_ptype", val_piece_type, 4'd0);

      run_move(4, 4, 4, 5, 0, 3);   // empty source
      run_move(0, 6, 0, 5, 0, 3);   // black piece on white's turn
      run_move(0, 0, 1, 0, 0, 3);   // own-piece target
      run_move(4, 1, 4, 3, 0, 3);   // e-pawn double step
      chk("e_pawn_dst", board_out[4][3], 4'd5);
      chk("e_pawn_src", board_out[4][1], 4'hF);
      run_move(4, 6, 4, 4, 1, 2);   // validator refuses
      run_move(4, 6, 4, 4, 2, 0);   // validator silent
      run_move(4, 6, 4, 4, 0, 1);
      run_move(2, 1, 2, 6, 0, 0);   // pawn to 7th, capturing black pawn
      run_move(0, 6, 0, 5, 0, 2);
      run_move(2, 6, 3, 7, 0, 1);   // promotes on top of black queen
      chk("promo_square", board_out[3][7], 4'd3);
      chk("promo_captured", captured_piece, 4'd9);
      run_move(0, 5, 0, 4, 0, 4);
      run_move(3, 7, 4, 7, 0, 2);   // takes black king
      chk("king_taken", game_over, 1'b1);

      req_old_x = 3'd0; req_old_y = 3'd4; req_new_x = 3'd0; req_new_y = 3'd3;
      move_req = 1'b1;
      ev = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         move_req = (i < 2);
         if (move_done === 1'b1 || move_rejected === 1'b1 || val_valid_input === 1'b1) ev++;
      end
      move_req = 1'b0;
      chk("game_over_absorbing", ev, 0);
      chk("game_over_ready", move_ready, 1'b0);
      check_state("game_over_hold");

      do_reset();
      check_state("reset2");
      chk("reset2_ready", move_ready, 1'b1);

      req_old_x = 3'd4; req_old_y = 3'd1; req_new_x = 3'd4; req_new_y = 3'd3;
      move_req = 1'b1;
      @(posedge clk); #1;
      move_req = 1'b0;
      ev = 0;
      for (int i = 0; i < 10 && ev == 0; i++) begin
         @(posedge clk); #1;
         if (val_valid_input === 1'b1) ev = 1;
      end
      chk("mid_launch_seen", ev, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      val_valid_output = 1'b1; val_valid_move = 1'b1;
      @(posedge clk); #1;
      val_valid_output = 1'b0; val_valid_move = 1'b0;
      ev = 0;
      for (int i = 0; i < 10; i++) begin
         if (move_done === 1'b1) ev++;
         @(posedge clk); #1;
      end
      chk("late_verdict_ignored", ev, 0);
      check_state("after_mid_reset");
      chk("after_mid_reset_ready", move_ready, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
